mult_job_sched: RTL

Queued job scheduler for the ROM -> register file -> combinational multiplier -> RAM datapath. It accepts multiply jobs (two ROM operand addresses plus a RAM destination) over a valid/ready handshake and buffers them in a small FIFO. It then sequences each job through the datapath with the same control signals the single-shot control unit drives: w_rf, DA, SA, SB, w_ram, rom_adr, ram_adr. It replaces that control unit in the top level so software or a test host can stream jobs back to back.

---
 rtl/mult_sched_pkg.sv | 25 ++
 rtl/sched_job_fifo.sv | 65 ++++++
 rtl/mult_job_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiply job scheduler.
package mult_sched_pkg;

   // Address width the job record is built for; the scheduler's AW defaults to this.
   localparam int JOB_AW = 3;

   // Register-file slots holding the two multiplier operands.
   localparam logic RF_REG_A = 1'b0;
   localparam logic RF_REG_B = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      STORE,
      DONE
   } state_e;

   typedef struct packed {
      logic [JOB_AW-1:0] adr1;
      logic [JOB_AW-1:0] adr2;
      logic [JOB_AW-1:0] dest;
   } job_t;

endpackage

// File: rtl/sched_job_fifo.sv
// Circular job FIFO: power-of-two depth, pointers wrap naturally, separate occupancy counter.
module sched_job_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Advance pointers and occupancy; simultaneous push/pop leaves count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mult_job_sched.sv
// Queued scheduler: buffers multiply jobs and sequences each through
// ROM -> register file -> multiplier -> RAM, one job per 4 cycles when streaming.
module mult_job_sched
   import mult_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = JOB_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_adr1,
   input  logic [AW-1:0] cmd_adr2,
   input  logic [AW-1:0] cmd_dest,
   input  logic          hold,
   output logic [AW-1:0] rom_adr,
   output logic          w_rf,
   output logic          DA,
   output logic          SA,
   output logic          SB,
   output logic          w_ram,
   output logic [AW-1:0] ram_adr,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] done_dest,
   output logic [AW:0]   pending
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_e        state_q, state_d;
   job_t          job_q, job_d;
   job_t          cmd_job, fifo_head;
   logic          fifo_full, fifo_empty;
   logic          push, pop;
   logic [CW-1:0] fifo_count;

   // No pass-through when full: ready depends only on registered occupancy and reset.
   assign cmd_ready = !fifo_full && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign pending   = rst ? '0 : (AW+1)'(fifo_count);
   assign busy      = (state_q != IDLE) && !rst;

   // Pack the incoming command into a job record.
   always_comb begin
      cmd_job      = '0;
      cmd_job.adr1 = cmd_adr1;
      cmd_job.adr2 = cmd_adr2;
      cmd_job.dest = cmd_dest;
   end

   sched_job_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(job_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (cmd_job),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Next state: IDLE and DONE may launch the next queued job unless held.
   always_comb begin
      state_d = state_q;
      job_d   = job_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (!fifo_empty && !hold) begin
               pop     = 1'b1;
               job_d   = fifo_head;
               state_d = LOAD_A;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD_A:  state_d = LOAD_B;
         LOAD_B:  state_d = STORE;
         STORE:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // State and job registers; reset drops the in-flight job.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         job_q   <= '0;
      end else begin
         state_q <= state_d;
         job_q   <= job_d;
      end
   end

   // Datapath control decode from registered state only; forced quiet during reset.
   always_comb begin
      w_rf      = 1'b0;
      DA        = RF_REG_A;
      SA        = RF_REG_A;
      SB        = RF_REG_A;
      w_ram     = 1'b0;
      rom_adr   = '0;
      ram_adr   = '0;
      done      = 1'b0;
      done_dest = '0;
      if (!rst) begin
         unique case (state_q)
            LOAD_A: begin
               rom_adr = job_q.adr1;
               DA      = RF_REG_A;
               w_rf    = 1'b1;
            end
            LOAD_B: begin
               rom_adr = job_q.adr2;
               DA      = RF_REG_B;
               w_rf    = 1'b1;
            end
            STORE: begin
               SA      = RF_REG_A;
               SB      = RF_REG_B;
               ram_adr = job_q.dest;
               w_ram   = 1'b1;
            end
            DONE: begin
               done      = 1'b1;
               done_dest = job_q.dest;
            end
            default: ;
         endcase
      end
   end

endmodule
